// File: rtl/encoder_input_filter.sv
// Quadrature front end: synchronizes raw A/B/Z pins, applies a programmable
// stable-time glitch filter and counts illegal (simultaneous) A/B transitions.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_SETTLE  | filters filling after reset; illegal detection disabled
// ST_RUN     | normal operation; illegal A/B transitions are counted
module encoder_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 8,
    parameter int ERR_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 A_in,
    input  logic                 B_in,
    input  logic                 Z_in,
    input  logic [FILT_BITS-1:0] filter_len,
    input  logic                 err_clear,
    output logic                 A,
    output logic                 B,
    output logic                 Z,
    output logic [ERR_BITS-1:0]  illegal_count,
    output logic                 illegal_flag
);

    localparam int NCH = 3;
    localparam logic [FILT_BITS+1:0] SYNC_W  = (FILT_BITS+2)'(SYNC_STAGES);
    localparam logic [ERR_BITS-1:0]  ERR_MAX = '1;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    logic [NCH-1:0]         raw;
    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [NCH-1:0]         sync_lvl;
    logic [NCH-1:0]         out_q, out_d;
    logic [FILT_BITS-1:0]   cnt_q [NCH];
    logic [FILT_BITS-1:0]   cnt_d [NCH];
    logic [FILT_BITS:0]     n_eff;

    state_t                 state_q, state_d;
    logic [FILT_BITS+1:0]   settle_q, settle_d;
    logic [FILT_BITS+1:0]   settle_target;

    logic                   illegal_evt;
    logic [ERR_BITS-1:0]    count_q, count_d;
    logic                   flag_q, flag_d;

    assign raw   = {Z_in, B_in, A_in};
    // A zero length behaves as a one-cycle filter.
    assign n_eff = (filter_len == '0) ? (FILT_BITS+1)'(1) : {1'b0, filter_len};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sync_lvl[i] = sync_q[i][SYNC_STAGES-1];
            out_d[i]    = out_q[i];
            cnt_d[i]    = '0;
            if (sync_lvl[i] != out_q[i]) begin
                if (({1'b0, cnt_q[i]} + (FILT_BITS+1)'(1)) >= n_eff) begin
                    out_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
                end
            end
        end
    end

    assign settle_target = SYNC_W + {1'b0, n_eff} + (FILT_BITS+2)'(1);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_SETTLE: begin
                settle_d = settle_q + (FILT_BITS+2)'(1);
                if (settle_d >= settle_target) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    assign illegal_evt = (state_q == ST_RUN) &&
                         (out_d[0] != out_q[0]) && (out_d[1] != out_q[1]);

    // An illegal event in the same cycle as err_clear takes priority.
    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (illegal_evt) begin
            flag_d = 1'b1;
            if (err_clear) begin
                count_d = ERR_BITS'(1);
            end else if (count_q != ERR_MAX) begin
                count_d = count_q + ERR_BITS'(1);
            end
        end else if (err_clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_q    <= '0;
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            out_q    <= out_d;
            state_q  <= state_d;
            settle_q <= settle_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign A             = out_q[0];
    assign B             = out_q[1];
    assign Z             = out_q[2];
    assign illegal_count = count_q;
    assign illegal_flag  = flag_q;

endmodule

// File: tb/tb_encoder_input_filter.sv
// Directed bench for encoder_input_filter: latency, glitch rejection,
// illegal-transition counting, saturation, clear priority and reset.
module tb_encoder_input_filter;

    logic        clk;
    logic        rst_n;
    logic        A_in, B_in, Z_in;
    logic [7:0]  filter_len;
    logic        err_clear;
    logic        A, B, Z;
    logic [15:0] illegal_count;
    logic        illegal_flag;

    int total;
    int bad;

    encoder_input_filter #(
        .SYNC_STAGES(2),
        .FILT_BITS  (8),
        .ERR_BITS   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A_in         (A_in),
        .B_in         (B_in),
        .Z_in         (Z_in),
        .filter_len   (filter_len),
        .err_clear    (err_clear),
        .A            (A),
        .B            (B),
        .Z            (Z),
        .illegal_count(illegal_count),
        .illegal_flag (illegal_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic exp_a;
        rst_n = 1'b0; A_in = 1'b1; B_in = 1'b1; Z_in = 1'b0;
        filter_len = 8'd5; err_clear = 1'b0;
        tick(3);
        total++;
        if ({A, B, Z, illegal_flag} !== 4'b0000 || illegal_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: A=%b B=%b Z=%b cnt=%0d flag=%b required all 0", A, B, Z, illegal_count, illegal_flag);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_a = (k >= 7);
            total++;
            if (A !== exp_a || B !== exp_a) begin
                bad++;
                $display("FAIL reset_rise edge%0d: A=%b B=%b required %b", k, A, B, exp_a);
            end
        end
        tick(5);
        total++;
        if (illegal_count !== 16'h0 || illegal_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_illegal: cnt=%0d flag=%b required 0 0", illegal_count, illegal_flag);
        end
    endtask

    task automatic test_glitch;
        logic exp_a;
        filter_len = 8'd5;
        A_in = 1'b0; tick(10);
        B_in = 1'b0; tick(10);
        total++;
        if (A !== 1'b0 || B !== 1'b0 || illegal_count !== 16'h0) begin
            bad++;
            $display("FAIL glitch_setup: A=%b B=%b cnt=%0d required 0 0 0", A, B, illegal_count);
        end
        A_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            if (k == 4) A_in = 1'b0;
            total++;
            if (A !== 1'b0) begin
                bad++;
                $display("FAIL glitch_4cyc edge%0d: A=%b required 0", k, A);
            end
        end
        A_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            if (k == 5) A_in = 1'b0;
            exp_a = (k >= 7 && k <= 11);
            total++;
            if (A !== exp_a) begin
                bad++;
                $display("FAIL pulse_5cyc edge%0d: A=%b required %b", k, A, exp_a);
            end
        end
    endtask

    task automatic test_filter_zero;
        logic exp_a;
        filter_len = 8'd0;
        A_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            exp_a = (k >= 3);
            total++;
            if (A !== exp_a) begin
                bad++;
                $display("FAIL filter_zero edge%0d: A=%b required %b", k, A, exp_a);
            end
        end
        A_in = 1'b0;
        tick(4);
        total++;
        if (A !== 1'b0) begin
            bad++;
            $display("FAIL filter_zero_fall: A=%b required 0", A);
        end
    endtask

    task automatic test_index;
        logic exp_z;
        filter_len = 8'd2;
        Z_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            exp_z = (k >= 4);
            total++;
            if (Z !== exp_z) begin
                bad++;
                $display("FAIL index_rise edge%0d: Z=%b required %b", k, Z, exp_z);
            end
        end
        A_in = 1'b1; Z_in = 1'b0;
        tick(6);
        total++;
        if (A !== 1'b1 || Z !== 1'b0 || illegal_count !== 16'h0) begin
            bad++;
            $display("FAIL index_not_checked: A=%b Z=%b cnt=%0d required 1 0 0", A, Z, illegal_count);
        end
        A_in = 1'b0;
        tick(6);
    endtask

    task automatic test_illegal;
        filter_len = 8'd3;
        A_in = 1'b1; B_in = 1'b1;
        tick(4);
        total++;
        if (A !== 1'b0 || B !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pre edge4: A=%b B=%b required 0 0", A, B);
        end
        tick(1);
        total++;
        if (A !== 1'b1 || B !== 1'b1 || illegal_count !== 16'd1 || illegal_flag !== 1'b1) begin
            bad++;
            $display("FAIL illegal_event: A=%b B=%b cnt=%0d flag=%b required 1 1 1 1", A, B, illegal_count, illegal_flag);
        end
        A_in = 1'b0; tick(10);
        B_in = 1'b0; tick(10);
        A_in = 1'b1; tick(10);
        B_in = 1'b1; tick(10);
        total++;
        if (A !== 1'b1 || B !== 1'b1 || illegal_count !== 16'd1) begin
            bad++;
            $display("FAIL quadrature_legal: A=%b B=%b cnt=%0d required 1 1 1", A, B, illegal_count);
        end
    endtask

    task automatic test_saturation;
        filter_len = 8'd0;
        for (int i = 0; i < 65540; i++) begin
            A_in = ~A_in; B_in = ~B_in;
            tick(1);
        end
        tick(3);
        total++;
        if (illegal_count !== 16'hFFFF || illegal_flag !== 1'b1 || A !== 1'b1 || B !== 1'b1) begin
            bad++;
            $display("FAIL saturate: cnt=%h flag=%b A=%b B=%b required ffff 1 1 1", illegal_count, illegal_flag, A, B);
        end
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        total++;
        if (illegal_count !== 16'h0 || illegal_flag !== 1'b0) begin
            bad++;
            $display("FAIL clear_alone: cnt=%0d flag=%b required 0 0", illegal_count, illegal_flag);
        end
        A_in = 1'b0; B_in = 1'b0;
        tick(2);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        total++;
        if (illegal_count !== 16'd1 || illegal_flag !== 1'b1 || A !== 1'b0 || B !== 1'b0) begin
            bad++;
            $display("FAIL clear_vs_event: cnt=%0d flag=%b A=%b B=%b required 1 1 0 0", illegal_count, illegal_flag, A, B);
        end
    endtask

    task automatic test_mid_change;
        filter_len = 8'd20;
        A_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            total++;
            if (A !== 1'b0) begin
                bad++;
                $display("FAIL midchange_wait edge%0d: A=%b required 0", k, A);
            end
        end
        filter_len = 8'd4;
        tick(1);
        total++;
        if (A !== 1'b1) begin
            bad++;
            $display("FAIL midchange_lower: A=%b required 1", A);
        end
        filter_len = 8'd5;
        A_in = 1'b0;
        tick(10);
        total++;
        if (A !== 1'b0) begin
            bad++;
            $display("FAIL midchange_restore: A=%b required 0", A);
        end
    endtask

    task automatic test_reset_mid;
        logic exp_a;
        filter_len = 8'd20;
        A_in = 1'b1;
        tick(8);
        rst_n = 1'b0;
        tick(1);
        total++;
        if (A !== 1'b0 || illegal_count !== 16'h0 || illegal_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: A=%b cnt=%0d flag=%b required 0 0 0", A, illegal_count, illegal_flag);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick(1);
            exp_a = (k >= 22);
            total++;
            if (A !== exp_a) begin
                bad++;
                $display("FAIL reset_mid_restart edge%0d: A=%b required %b", k, A, exp_a);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_glitch();
        test_filter_zero();
        test_index();
        test_illegal();
        test_saturation();
        test_mid_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_input_filter.md
Name: encoder_input_filter

Overview:
- Conditioning stage directly upstream of the encoder block.
- Takes raw asynchronous quadrature pins A/B/Z from the board connector, synchronizes them into clk and rejects glitches with a programmable stable-time filter.
- Drives clean A/B/Z into the encoder's A/B/Z inputs.
- Counts illegal quadrature transitions (A and B toggling together) so firmware can detect noise or overspeed.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per channel (legal 2..4)
FILT_BITS, 8, width of filter_len and of the per-channel stable-time counters
ERR_BITS, 16, width of illegal_count

Ports:
clk  input  1  system clock (200 MHz)
rst_n  input  1  synchronous, active-low reset
A_in  input  1  raw encoder channel A, asynchronous
B_in  input  1  raw encoder channel B, asynchronous
Z_in  input  1  raw index pulse, asynchronous
filter_len  input  FILT_BITS  consecutive cycles a new level must persist before output follows; 0 treated as 1
err_clear  input  1  single-cycle pulse; clears illegal_count and illegal_flag
A  output  1  filtered channel A, to encoder
B  output  1  filtered channel B, to encoder
Z  output  1  filtered index, to encoder
illegal_count  output  ERR_BITS  number of illegal A/B transitions, saturating
illegal_flag  output  1  sticky; set on any illegal transition

Behaviour:
- Reset: all synchronizer flops, A, B, Z, stable counters, settle counter, illegal_count and illegal_flag are 0; FSM enters SETTLE. Reset is sampled only on the rising edge of clk. Asserting it mid-operation discards any partially accumulated filter count.
- Synchronizer: SYNC_STAGES-flop chain per channel. No logic between the flops. sync_x is the last flop.
- Filter, per channel, identical for A, B and Z:
  - Let N = max(filter_len, 1).
  - If sync_x == x, cnt_x <= 0.
  - Otherwise, if cnt_x + 1 >= N, then x <= sync_x and cnt_x <= 0.
  - Otherwise, cnt_x <= cnt_x + 1.
- Latency: the edge that first samples a new raw level is edge 1. The output takes the new level on edge SYNC_STAGES + N. With defaults and filter_len = 5, that is edge 7.
- Glitch rejection: any level at sync_x lasting fewer than N cycles never reaches the output, and its count is discarded.
- filter_len is compared live (>=). Lowering it while a count is in progress can cause the output to update on the next edge. Raising it extends the wait.
- Counters never overflow: N <= 2^FILT_BITS - 1, and cnt resets on reaching N.
- FSM, two states:
  - SETTLE: the settle counter (FILT_BITS+2 bits) increments every cycle. Move to RUN when it reaches SYNC_STAGES + N + 1. Illegal detection is disabled in SETTLE, so an input that is high at reset release is not counted.
  - RUN: stays in RUN until reset.
- Illegal transition: in RUN, an illegal event is a cycle in which the next values of A and B both differ from their current values, i.e. both outputs toggle on the same edge. Z is not checked.
- On an illegal event:
  - illegal_flag <= 1.
  - illegal_count increments, saturating at 2^ERR_BITS - 1.
- err_clear:
  - Alone: illegal_count <= 0 and illegal_flag <= 0 on the next edge.
  - Same cycle as an illegal event: the event wins over the clear, giving illegal_count = 1 and illegal_flag = 1.
- Outputs A, B, Z, illegal_count and illegal_flag are all registered. No combinational path from any input to any output.

Test Plan:
- Reset with A_in = B_in = 1 and filter_len = 5 -> A and B rise together on edge 7 after release; FSM passes SETTLE; illegal_count = 0 and illegal_flag = 0.
- filter_len = 5, A_in high-pulse lasting 4 clk cycles, then a 5-cycle pulse -> first pulse produces no change on A; second pulse produces a 5-cycle-wide pulse on A, delayed 6 cycles (SYNC_STAGES + N - 1) from its first sampled edge.
- filter_len = 0 -> behaves as filter_len = 1; an A_in step appears on A at edge 3.
- In RUN, with filter_len = 3, A_in and B_in toggle on the same clk edge -> A and B toggle together; illegal_count = 1 and illegal_flag = 1. Then a legal 4-step quadrature cycle (10 cycles per step) -> count stays 1.
- Force 65540 illegal toggles -> illegal_count saturates at 0xFFFF. Then err_clear alone -> count 0, flag 0. Then err_clear coincident with an illegal event -> count 1, flag 1.
- Mid-count filter change: filter_len = 20 and A_in steps; after 10 cycles at sync_A, set filter_len = 4 -> A updates on the next edge. Also assert rst_n mid-count -> A stays 0 and cnt is discarded.
